// File: rtl/restoring_div_16_pkg.sv
// Shared arithmetic package for the multi-cycle divider.
//   DIV_WIDTH  : default operand width
//   ST_*       : FSM state encoding (IDLE, RUN, DONE)
//   cnt_w()    : iteration counter width for a given operand width
package restoring_div_16_pkg;

  localparam int DIV_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/restoring_div_16_cla_sub_n.sv
// cla_sub_n: N-bit subtractor a - b computed as a + ~b + 1 with 4-bit
// carry-lookahead groups. Group carries come from group generate/propagate;
// each bit carry is a lookahead expression from its group carry-in.
//   a, b : operands
//   diff : a - b (mod 2^N)
//   cout : carry out of bit N-1; 1 means no borrow (a >= b)
module cla_sub_n #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);
  // Only full groups need a group carry-out; gc[NG] is the carry into bit 4*NG <= N.
  localparam int NG = N / 4;

  logic [N-1:0] g, p;
  logic [N:0]   c;
  logic [NG:0]  gc;

  assign g = a & ~b;
  assign p = a ^ ~b;

  always_comb begin
    logic t;
    t  = 1'b0;
    gc = '0;
    c  = '0;
    gc[0] = 1'b1;  // +1 of the two's complement
    for (int i = 0; i < NG; i++) begin
      gc[i+1] = g[4*i+3]
              | (p[4*i+3] & g[4*i+2])
              | (p[4*i+3] & p[4*i+2] & g[4*i+1])
              | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i])
              | (p[4*i+3] & p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
    for (int bi = 0; bi <= N; bi++) begin
      int base;
      base = (bi / 4) * 4;
      t = gc[bi/4];
      for (int k = base; k < bi; k++) t = t & p[k];
      c[bi] = t;
      for (int k = base; k < bi; k++) begin
        t = g[k];
        for (int m = k + 1; m < bi; m++) t = t & p[m];
        c[bi] = c[bi] | t;
      end
    end
  end

  assign diff = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/restoring_div_16.sv
// restoring_div_16: sequential unsigned restoring divider, one quotient bit
// per cycle using a WIDTH+1-bit CLA subtractor.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, taken when ready=1
//   dividend, divisor   : operands, captured on accepted start
//   ready / busy / done : IDLE|DONE / RUN / single-cycle result pulse
//   quotient, remainder : held from done until the next accepted start
//   div_err             : only with DIV_ZERO_ERR_EN; divisor was zero
// Build option: DIV_ZERO_ERR_EN short-circuits a zero divisor straight to DONE.
module restoring_div_16
  import restoring_div_16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic             div_err
`endif
);
  localparam int CW = cnt_w(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_r, dvs, q_nxt;
  logic [WIDTH:0]   r_r, t, diff, r_nxt;
  logic             cout, accept, last;
  logic             unused_rmsb;

  assign ready  = (state == ST_IDLE) | (state == ST_DONE);
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);
  assign accept = start & ready;
  assign last   = (count == CW'(WIDTH - 1));

  // Partial remainder never exceeds divisor-1 after a step, so its MSB is
  // always 0 when shifted; T needs the extra bit only transiently.
  assign t           = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
  assign unused_rmsb = r_r[WIDTH];

  cla_sub_n #(.N(WIDTH + 1)) u_sub (
    .a    (t),
    .b    ({1'b0, dvs}),
    .diff (diff),
    .cout (cout)
  );

  // cout=1: no borrow, keep the difference and shift in a 1.
  assign q_nxt = {q_r[WIDTH-2:0], cout};
  assign r_nxt = cout ? diff : t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      q_r       <= '0;
      r_r       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_ERR_EN
      div_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            dvs   <= divisor;
            q_r   <= dividend;
            r_r   <= '0;
            count <= '0;
`ifdef DIV_ZERO_ERR_EN
            if (divisor == '0) begin
              state     <= ST_DONE;
              quotient  <= '1;
              remainder <= dividend;
              div_err   <= 1'b1;
            end else begin
              state   <= ST_RUN;
              div_err <= 1'b0;
            end
`else
            state <= ST_RUN;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          q_r   <= q_nxt;
          r_r   <= r_nxt;
          count <= count + 1'b1;
          if (last) begin
            state     <= ST_DONE;
            quotient  <= q_nxt;
            remainder <= r_nxt[WIDTH-1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div_16.sv
// Directed bench for restoring_div_16: reset state, latency/handshake,
// boundary quotients, divide-by-zero (both build options), mid-run reset,
// and a back-to-back chain of hand-computed vectors.
module tb_restoring_div_16;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        ready, busy, done;
  logic [15:0] quotient, remainder;
`ifdef DIV_ZERO_ERR_EN
  logic        div_err;
`endif

  int checks   = 0;
  int failures = 0;

  restoring_div_16 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_ERR_EN
    ,
    .div_err   (div_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise start in the current cycle; returns one cycle later with start low.
  task automatic issue(input logic [15:0] dd, input logic [15:0] dv);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Waits for done; lat counts cycles since the start cycle (cycle 0).
  task automatic wait_done(input int lat0, input int limit, output int lat, output int bc);
    lat = lat0;
    bc  = 0;
    while (done !== 1'b1 && lat < limit) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL done_timeout: got no done expected done within %0d cycles", limit);
    end
  endtask

  typedef struct {
    logic [15:0] dd, dv, q, r;
  } vec_t;

  initial begin
    int   lat, bc, npulse;
    vec_t v[6];

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
`ifdef DIV_ZERO_ERR_EN
    chk("rst_err", div_err, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 100/7: busy cycles 1..16, done in cycle 17
    issue(16'd100, 16'd7);
    wait_done(1, 40, lat, bc);
    chk("d100_lat", lat, 17);
    chk("d100_busy_cycles", bc, 16);
    chk("d100_busy_at_done", busy, 0);
    chk("d100_q", quotient, 14);
    chk("d100_r", remainder, 2);
    @(negedge clk);
    chk("d100_done_pulse", done, 0);
    chk("d100_ready_after", ready, 1);
    repeat (3) @(negedge clk);
    chk("d100_q_hold", quotient, 14);
    chk("d100_r_hold", remainder, 2);

    issue(16'hFFFF, 16'h0001);
    wait_done(1, 40, lat, bc);
    chk("ffff_1_q", quotient, 16'hFFFF);
    chk("ffff_1_r", remainder, 0);
    @(negedge clk);

    issue(16'hFFFF, 16'hFFFF);
    wait_done(1, 40, lat, bc);
    chk("ffff_ffff_q", quotient, 1);
    chk("ffff_ffff_r", remainder, 0);
    @(negedge clk);

    issue(16'd5, 16'd9);
    wait_done(1, 40, lat, bc);
    chk("d5_9_q", quotient, 0);
    chk("d5_9_r", remainder, 5);
    @(negedge clk);

    // Divide by zero
    issue(16'h1234, 16'h0000);
    wait_done(1, 40, lat, bc);
`ifdef DIV_ZERO_ERR_EN
    chk("dz_lat", lat, 1);
    chk("dz_err", div_err, 1);
`else
    chk("dz_lat", lat, 17);
`endif
    chk("dz_q", quotient, 16'hFFFF);
    chk("dz_r", remainder, 16'h1234);
    @(negedge clk);
`ifdef DIV_ZERO_ERR_EN
    chk("dz_err_hold", div_err, 1);
`endif

    // Handshake 1: start pulse in cycle 5 is ignored
    issue(16'd50, 16'd3);
    repeat (4) @(negedge clk);
    dividend = 16'd9; divisor = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, 40, lat, bc);
    chk("hs1_lat", lat, 17);
    chk("hs1_q", quotient, 16);
    chk("hs1_r", remainder, 2);
`ifdef DIV_ZERO_ERR_EN
    chk("hs1_err_clr", div_err, 0);
`endif

    // Handshake 2: start in the done cycle is accepted
    issue(16'd9, 16'd2);
    chk("hs2_done_drop", done, 0);
    chk("hs2_busy", busy, 1);
    wait_done(1, 40, lat, bc);
    chk("hs2_lat", lat, 17);
    chk("hs2_q", quotient, 4);
    chk("hs2_r", remainder, 1);
    @(negedge clk);

    // Reset in cycle 8 of a run: no done afterwards
    issue(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_q", quotient, 0);
    chk("mrst_r", remainder, 0);
    npulse = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) npulse++;
    end
    chk("mrst_no_done", npulse, 0);

    // Back-to-back chain, each next start raised in the done cycle
    v[0] = '{16'd1000,  16'd3,     16'd333,  16'd1};
    v[1] = '{16'd43981, 16'd18,    16'd2443, 16'd7};
    v[2] = '{16'd65535, 16'd256,   16'd255,  16'd255};
    v[3] = '{16'd12345, 16'd12345, 16'd1,    16'd0};
    v[4] = '{16'h8000,  16'h7FFF,  16'd1,    16'd1};
    v[5] = '{16'd1,     16'hFFFF,  16'd0,    16'd1};
    issue(v[0].dd, v[0].dv);
    for (int i = 0; i < 6; i++) begin
      wait_done(1, 40, lat, bc);
      chk($sformatf("b2b%0d_lat", i), lat, 17);
      chk($sformatf("b2b%0d_q", i), quotient, v[i].q);
      chk($sformatf("b2b%0d_r", i), remainder, v[i].r);
      if (i < 5) issue(v[i+1].dd, v[i+1].dv);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
